// File: rtl/ariane_bitmanip_pkg.sv
// Shared bit-manipulation definitions: function codes for the bit-count
// datapath and the sequencer's state encoding and defaults.
package ariane_bitmanip_pkg;

  localparam int BM_FUNC_NBITS = 4;

  localparam logic [BM_FUNC_NBITS-1:0] BM_FUNC_CLZ  = 4'd0;
  localparam logic [BM_FUNC_NBITS-1:0] BM_FUNC_CTZ  = 4'd1;
  localparam logic [BM_FUNC_NBITS-1:0] BM_FUNC_CPOP = 4'd2;

  localparam int BM_CTRL_DEPTH = 2;
  // Mirrors ariane_pkg::TRANS_ID_BITS so this slice elaborates standalone.
  localparam int BM_TRANS_ID_BITS = 3;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } bm_ctrl_state_e;

endpackage

// File: rtl/bitmanip_tag_fifo.sv
// In-order tag FIFO with wrap-bit pointers; clr_i empties it in one cycle.
module bitmanip_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
  logic [IW-1:0]                 wr_idx, rd_idx;

  // Pointers run modulo 2*DEPTH; the extra bit tells full from empty.
  assign wr_idx  = IW'(wr_ptr_q & CW'(DEPTH - 1));
  assign rd_idx  = IW'(rd_ptr_q & CW'(DEPTH - 1));
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign data_o  = mem_q[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_idx] = data_i;
        wr_ptr_d      = wr_ptr_q + CW'(1);
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule

// File: rtl/bitmanip_seq_ctrl.sv
// Issue-side sequencer for the bit-count datapath: registers ops, tracks tags
// in order, buffers results for writeback and drains squashed work on flush.
module bitmanip_seq_ctrl
  import ariane_bitmanip_pkg::*;
#(
  parameter int DEPTH         = BM_CTRL_DEPTH,
  parameter int TRANS_ID_BITS = BM_TRANS_ID_BITS,
  parameter int FUNC_BITS     = BM_FUNC_NBITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [FUNC_BITS-1:0]     issue_func_i,
  input  logic [63:0]              issue_operand_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  output logic                     dp_din_valid_o,
  input  logic                     dp_din_ready_i,
  output logic [63:0]              dp_rs1_o,
  output logic [FUNC_BITS-1:0]     dp_func_o,
  input  logic                     dp_dout_valid_i,
  output logic                     dp_dout_ready_o,
  input  logic [63:0]              dp_rd_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [63:0]              wb_result_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  bm_ctrl_state_e             state_q, state_d;
  logic [CW-1:0]              drop_cnt_q, drop_cnt_d;
  logic                       din_valid_q, din_valid_d;
  logic [63:0]                rs1_q, rs1_d;
  logic [FUNC_BITS-1:0]       func_q, func_d;
  logic                       wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0]   wb_id_q, wb_id_d;
  logic [63:0]                wb_res_q, wb_res_d;

  logic                       fifo_full, fifo_empty, fifo_clr, fifo_pop;
  logic [CW-1:0]              fifo_count;
  logic [TRANS_ID_BITS-1:0]   head_tag;
  logic                       din_hs, dout_hs, issue_hs, in_run;

  assign in_run          = (state_q == RUN);
  assign issue_ready_o   = in_run & ~flush_i & ~fifo_full & (~din_valid_q | dp_din_ready_i);
  assign dp_dout_ready_o = ~wb_valid_q | wb_ready_i | ~in_run;
  assign issue_hs        = issue_valid_i & issue_ready_o;
  assign din_hs          = din_valid_q & dp_din_ready_i;
  assign dout_hs         = dp_dout_valid_i & dp_dout_ready_o;
  assign fifo_pop        = dout_hs & in_run & ~flush_i;

  assign dp_din_valid_o = din_valid_q;
  assign dp_rs1_o       = rs1_q;
  assign dp_func_o      = func_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_trans_id_o  = wb_id_q;
  assign wb_result_o    = wb_res_q;

  bitmanip_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRANS_ID_BITS)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr),
    .push_i  (issue_hs),
    .data_i  (issue_trans_id_i),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .data_o  (head_tag)
  );

  always_comb begin
    state_d     = state_q;
    drop_cnt_d  = drop_cnt_q;
    din_valid_d = din_valid_q;
    rs1_d       = rs1_q;
    func_d      = func_q;
    wb_valid_d  = wb_valid_q;
    wb_id_d     = wb_id_q;
    wb_res_d    = wb_res_q;
    fifo_clr    = 1'b0;

    if (din_hs) din_valid_d = 1'b0;
    if (issue_hs) begin
      din_valid_d = 1'b1;
      rs1_d       = issue_operand_i;
      func_d      = issue_func_i;
    end
    if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (flush_i) begin
          din_valid_d = 1'b0;
          wb_valid_d  = 1'b0;
          fifo_clr    = 1'b1;
          // Ops still owed by the datapath: exclude the one never handed over
          // and the one returning right now (its result is thrown away).
          drop_cnt_d  = fifo_count - CW'(din_valid_q & ~dp_din_ready_i) - CW'(dout_hs);
          if (drop_cnt_d != '0) state_d = DRAIN;
        end else if (dout_hs) begin
          wb_valid_d = 1'b1;
          wb_res_d   = dp_rd_i;
          wb_id_d    = head_tag;
        end
      end
      DRAIN: begin
        if (dout_hs) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_d == '0) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      drop_cnt_q  <= '0;
      din_valid_q <= 1'b0;
      rs1_q       <= '0;
      func_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_id_q     <= '0;
      wb_res_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      din_valid_q <= din_valid_d;
      rs1_q       <= rs1_d;
      func_q      <= func_d;
      wb_valid_q  <= wb_valid_d;
      wb_id_q     <= wb_id_d;
      wb_res_q    <= wb_res_d;
    end
  end

  a_dout_has_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    (dout_hs && in_run) |-> !fifo_empty);

endmodule

// File: tb/tb_bitmanip_seq_ctrl.sv
// Directed bench for bitmanip_seq_ctrl with a variable-latency bit-count model.
module tb_bitmanip_seq_ctrl;
  import ariane_bitmanip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [3:0]  issue_func_i;
  logic [63:0] issue_operand_i;
  logic [2:0]  issue_trans_id_i;
  logic        dp_din_valid_o, dp_din_ready_i;
  logic [63:0] dp_rs1_o;
  logic [3:0]  dp_func_o;
  logic        dp_dout_valid_i = 1'b0, dp_dout_ready_o;
  logic [63:0] dp_rd_i = '0;
  logic        wb_valid_o, wb_ready_i;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_result_o;

  always #5 clk = ~clk;

  bitmanip_seq_ctrl #(.DEPTH(2), .TRANS_ID_BITS(3), .FUNC_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_func_i(issue_func_i), .issue_operand_i(issue_operand_i),
    .issue_trans_id_i(issue_trans_id_i),
    .dp_din_valid_o(dp_din_valid_o), .dp_din_ready_i(dp_din_ready_i),
    .dp_rs1_o(dp_rs1_o), .dp_func_o(dp_func_o),
    .dp_dout_valid_i(dp_dout_valid_i), .dp_dout_ready_o(dp_dout_ready_o),
    .dp_rd_i(dp_rd_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bitcnt(input logic [3:0] f, input logic [63:0] x);
    int n = 0;
    case (f)
      BM_FUNC_CLZ:  for (int i = 63; i >= 0 && !x[i]; i--) n++;
      BM_FUNC_CTZ:  for (int i = 0; i < 64 && !x[i]; i++) n++;
      default:      for (int i = 0; i < 64; i++) n += int'(x[i]);
    endcase
    return 64'(n);
  endfunction

  // Datapath model: accepted ops return in order after lat cycles.
  typedef struct { int due; logic [63:0] res; } dp_op_t;
  dp_op_t dpq[$];
  int cyc = 0, lat = 1;
  logic din_hs_s = 1'b0, dout_hs_s = 1'b0, rst_s = 1'b0;
  logic [63:0] din_rs1_s = '0;
  logic [3:0]  din_func_s = '0;

  always @(posedge clk) begin
    din_hs_s   <= dp_din_valid_o & dp_din_ready_i;
    din_rs1_s  <= dp_rs1_o;
    din_func_s <= dp_func_o;
    dout_hs_s  <= dp_dout_valid_i & dp_dout_ready_o;
    rst_s      <= rst_i;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_s) dpq.delete();
    else begin
      if (dout_hs_s && dpq.size() > 0) dpq.delete(0);
      if (din_hs_s) dpq.push_back('{cyc + lat - 1, bitcnt(din_func_s, din_rs1_s)});
    end
    if (dpq.size() > 0 && dpq[0].due <= cyc) begin
      dp_dout_valid_i = 1'b1;
      dp_rd_i         = dpq[0].res;
    end else begin
      dp_dout_valid_i = 1'b0;
      dp_rd_i         = '0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [63:0] op, input logic [2:0] tag);
    issue_valid_i    = 1'b1;
    issue_func_i     = f;
    issue_operand_i  = op;
    issue_trans_id_i = tag;
    #1;
  endtask

  logic [3:0]  t2_f   [3] = '{BM_FUNC_CPOP, BM_FUNC_CTZ, BM_FUNC_CLZ};
  logic [63:0] t2_op  [3] = '{64'hFF, 64'h8000, 64'h1};
  logic [63:0] t2_exp [3] = '{64'd8, 64'd15, 64'd63};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, got, drops;
    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_func_i = '0;
    issue_operand_i = '0; issue_trans_id_i = '0; dp_din_ready_i = 1'b1; wb_ready_i = 1'b1;
    repeat (2) tick();
    chk("rst_din_valid", dp_din_valid_o, 0);
    chk("rst_rs1", dp_rs1_o, 0);
    chk("rst_func", dp_func_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_id", wb_trans_id_o, 0);
    chk("rst_wb_res", wb_result_o, 0);
    chk("rst_state", 64'(dut.state_q), 64'(RUN));
    rst_i = 1'b0;

    // 1: single CLZ, 1-cycle issue latency, 1-cycle datapath
    tick();
    issue(BM_FUNC_CLZ, 64'hF0, 3'd3);
    chk("t1_rdy", issue_ready_o, 1);
    tick();
    issue_valid_i = 1'b0;
    chk("t1_din_valid", dp_din_valid_o, 1);
    chk("t1_din_rs1", dp_rs1_o, 64'hF0);
    chk("t1_din_func", dp_func_o, 64'(BM_FUNC_CLZ));
    tick();
    chk("t1_din_done", dp_din_valid_o, 0);
    chk("t1_wb_early", wb_valid_o, 0);
    tick();
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_wb_res", wb_result_o, 64'd56);
    chk("t1_wb_id", wb_trans_id_o, 3);
    tick();
    chk("t1_wb_clear", wb_valid_o, 0);

    // 2: writeback backpressure fills FIFO + result register
    repeat (3) tick();
    wb_ready_i = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      issue(t2_f[t-1], t2_op[t-1], 3'(t));
      w = 0;
      while (!issue_ready_o && w < 10) begin tick(); w++; end
      chk("t2_accept", 64'(w < 10), 1);
      tick();
    end
    issue(BM_FUNC_CLZ, 64'h2, 3'd4);
    repeat (3) begin
      chk("t2_full_rdy", issue_ready_o, 0);
      tick();
    end
    chk("t2_held_id", wb_trans_id_o, 1);
    issue_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    got = 0; w = 0;
    while (got < 3 && w < 30) begin
      if (wb_valid_o) begin
        chk("t2_order_id", wb_trans_id_o, 64'(got + 1));
        chk("t2_order_res", wb_result_o, t2_exp[got]);
        got++;
      end
      tick(); w++;
    end
    chk("t2_retired", 64'(got), 3);

    // 3: din stall holds payload and blocks issue
    repeat (3) tick();
    dp_din_ready_i = 1'b0;
    issue(BM_FUNC_CPOP, 64'hF0F0, 3'd5);
    tick();
    issue_valid_i = 1'b0;
    repeat (4) begin
      chk("t3_valid", dp_din_valid_o, 1);
      chk("t3_rs1", dp_rs1_o, 64'hF0F0);
      chk("t3_func", dp_func_o, 64'(BM_FUNC_CPOP));
      chk("t3_rdy", issue_ready_o, 0);
      tick();
    end
    dp_din_ready_i = 1'b1;
    w = 0;
    while (!wb_valid_o && w < 10) begin tick(); w++; end
    chk("t3_wb_id", wb_trans_id_o, 5);
    chk("t3_wb_res", wb_result_o, 64'd8);

    // 4: flush with two ops inside a 3-cycle datapath
    repeat (4) tick();
    lat = 3;
    issue(BM_FUNC_CLZ, 64'h1, 3'd1);
    tick();
    issue(BM_FUNC_CTZ, 64'h4, 3'd2);
    tick();
    issue_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_state", 64'(dut.state_q), 64'(DRAIN));
    chk("t4_drop", 64'(dut.drop_cnt_q), 2);
    chk("t4_rdy", issue_ready_o, 0);
    chk("t4_dout_rdy", dp_dout_ready_o, 1);
    drops = 0; w = 0;
    while (drops < 2 && w < 10) begin
      if (dp_dout_valid_i && dp_dout_ready_o) drops++;
      chk("t4_no_wb", wb_valid_o, 0);
      tick(); w++;
    end
    chk("t4_drops", 64'(drops), 2);
    chk("t4_reopen", issue_ready_o, 1);
    chk("t4_run", 64'(dut.state_q), 64'(RUN));
    chk("t4_no_wb_end", wb_valid_o, 0);

    // 5: flush coincident with a dout handshake and a new issue
    repeat (4) tick();
    lat = 1;
    issue(BM_FUNC_CLZ, 64'hF0, 3'd4);
    tick();
    issue(BM_FUNC_CTZ, 64'h10, 3'd5);
    tick();
    issue(BM_FUNC_CPOP, 64'h3, 3'd6);
    flush_i = 1'b1;
    #1;
    chk("t5_rdy", issue_ready_o, 0);
    chk("t5_dout_hs", 64'(dp_dout_valid_i & dp_dout_ready_o), 1);
    tick();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    chk("t5_state", 64'(dut.state_q), 64'(DRAIN));
    chk("t5_drop", 64'(dut.drop_cnt_q), 1);
    chk("t5_no_wb", wb_valid_o, 0);
    chk("t5_no_din", dp_din_valid_o, 0);
    tick();
    chk("t5_run", 64'(dut.state_q), 64'(RUN));
    chk("t5_reopen", issue_ready_o, 1);
    chk("t5_no_wb2", wb_valid_o, 0);

    // 6a: reset with a held result and a stalled din
    repeat (4) tick();
    wb_ready_i = 1'b0;
    issue(BM_FUNC_CPOP, '1, 3'd1);
    tick();
    issue(BM_FUNC_CLZ, 64'h1, 3'd2);
    tick();
    issue_valid_i = 1'b0;
    tick();
    chk("t6_pre_wb", wb_valid_o, 1);
    dp_din_ready_i = 1'b0;
    issue(BM_FUNC_CTZ, 64'h8, 3'd7);
    tick();
    issue_valid_i = 1'b0;
    chk("t6_pre_din", dp_din_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_din_valid", dp_din_valid_o, 0);
    chk("t6_rs1", dp_rs1_o, 0);
    chk("t6_func", dp_func_o, 0);
    chk("t6_wb_valid", wb_valid_o, 0);
    chk("t6_wb_id", wb_trans_id_o, 0);
    chk("t6_wb_res", wb_result_o, 0);
    chk("t6_fifo", 64'(dut.fifo_count), 0);
    dp_din_ready_i = 1'b1;
    wb_ready_i = 1'b1;
    #1;
    chk("t6_rdy", issue_ready_o, 1);

    // 6b: reset in the middle of DRAIN
    repeat (3) tick();
    lat = 3;
    issue(BM_FUNC_CLZ, 64'h1, 3'd3);
    tick();
    issue_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6b_drain", 64'(dut.state_q), 64'(DRAIN));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6b_state", 64'(dut.state_q), 64'(RUN));
    chk("t6b_drop", 64'(dut.drop_cnt_q), 0);
    chk("t6b_fifo", 64'(dut.fifo_count), 0);
    chk("t6b_wb", wb_valid_o, 0);
    #1;
    chk("t6b_rdy", issue_ready_o, 1);
    repeat (5) tick();
    chk("t6b_quiet", wb_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
